// File: rtl/biquad_pkg.sv
// ============================================================================
// Package     : biquad_pkg
// Description : Shared loader state encoding, coefficient slots and defaults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package biquad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FETCH     = 2'd1,
        ST_NEXT      = 2'd2,
        ST_WAIT_SWAP = 2'd3
    } loader_state_t;

    // Coefficient slot order within one section
    localparam int B0 = 0;
    localparam int B1 = 1;
    localparam int B2 = 2;
    localparam int A1 = 3;
    localparam int A2 = 4;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

`default_nettype wire

// File: rtl/biquad_coeff_bank.sv
// ============================================================================
// Module      : biquad_coeff_bank
// Description : Shadow/active coefficient register file with atomic swap and
//               registered read port (new set visible right after the swap).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module biquad_coeff_bank #(
    parameter int  DATA_W = 64,
    parameter int  N_SECT = 4,
    parameter int  N_COEF = 5,
    parameter int  WR_W   = 5,
    localparam int SECT_W = (N_SECT > 1) ? $clog2(N_SECT) : 1,
    localparam int IDX_W  = (N_COEF > 1) ? $clog2(N_COEF) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [WR_W-1:0]   i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_dat,
    input  logic              i_swap,
    input  logic [SECT_W-1:0] i_rd_sect,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [DATA_W-1:0] o_rd_dat
);

    localparam int c_N_WORDS = N_SECT * N_COEF;

    logic [DATA_W-1:0] r_shadow [c_N_WORDS];
    logic [DATA_W-1:0] r_active [c_N_WORDS];
    logic [DATA_W-1:0] r_rd_dat;
    logic [DATA_W-1:0] w_rd_sel;

    // Out-of-range section/index fall through to zero; during a swap the
    // shadow value is forwarded so the read port tracks the new set at once.
    always_comb begin
        w_rd_sel = '0;
        for (int s = 0; s < N_SECT; s++) begin
            for (int c = 0; c < N_COEF; c++) begin
                if (i_rd_sect == SECT_W'(s) && i_rd_idx == IDX_W'(c)) begin
                    w_rd_sel = i_swap ? r_shadow[s*N_COEF + c] : r_active[s*N_COEF + c];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_N_WORDS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
            r_rd_dat <= '0;
        end else begin
            for (int i = 0; i < c_N_WORDS; i++) begin
                if (i_wr_en && i_wr_addr == WR_W'(i)) begin
                    r_shadow[i] <= i_wr_dat;
                end
                if (i_swap) begin
                    r_active[i] <= r_shadow[i];
                end
            end
            r_rd_dat <= w_rd_sel;
        end
    end

    assign o_rd_dat = r_rd_dat;

endmodule

`default_nettype wire

// File: rtl/wb_biquad_coeff_loader.sv
// ============================================================================
// Module      : wb_biquad_coeff_loader
// Description : Wishbone master fetching N_SECT x N_COEF biquad coefficients
//               into a shadow bank, swapped in atomically on sample strobe.
// Options     : COEFF_CHECKSUM_EN - fetch and verify a trailing XOR word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_biquad_coeff_loader
    import biquad_pkg::*;
#(
    parameter int  DATA_W  = 64,
    parameter int  ADDR_W  = 9,
    parameter int  N_SECT  = 4,
    parameter int  N_COEF  = 5,
    parameter int  TIMEOUT = DEFAULT_TIMEOUT,
    localparam int SECT_W  = (N_SECT > 1) ? $clog2(N_SECT) : 1,
    localparam int IDX_W   = (N_COEF > 1) ? $clog2(N_COEF) : 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    output logic              coeff_wbm_cyc_o,
    output logic              coeff_wbm_stb_o,
    output logic [ADDR_W-1:0] coeff_wbm_adr_o,
    input  logic [DATA_W-1:0] coeff_wbm_dat_i,
    input  logic              coeff_wbm_ack_i,
    input  logic [ADDR_W-1:0] base_adr_i,
    input  logic              load_i,
    input  logic              sample_stb_i,
    input  logic [SECT_W-1:0] rd_sect_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [DATA_W-1:0] rd_dat_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int c_N_COEF_WORDS = N_SECT * N_COEF;
`ifdef COEFF_CHECKSUM_EN
    localparam int c_N_WORDS = c_N_COEF_WORDS + 1;
`else
    localparam int c_N_WORDS = c_N_COEF_WORDS;
`endif
    localparam int W_W   = $clog2(c_N_WORDS + 1);
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [W_W-1:0]   c_LAST_W   = W_W'(c_N_WORDS - 1);
    localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'(TIMEOUT - 1);

    loader_state_t     r_state;
    loader_state_t     w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [W_W-1:0]    r_w;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              w_cyc;
    logic              w_start;
    logic              w_wr_en;
    logic              w_abort;
    logic              w_swap;

`ifdef COEFF_CHECKSUM_EN
    localparam logic [W_W-1:0] c_CK_W = W_W'(c_N_COEF_WORDS);
    logic [DATA_W-1:0] r_xor;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_xor <= '0;
        end else if (w_start) begin
            r_xor <= '0;
        end else if (w_wr_en) begin
            r_xor <= r_xor ^ coeff_wbm_dat_i;
        end
    end
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cyc       = 1'b0;
        w_start     = 1'b0;
        w_wr_en     = 1'b0;
        w_abort     = 1'b0;
        w_swap      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load_i) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_cyc = 1'b1;
                if (coeff_wbm_ack_i) begin
                    w_state_nxt = ST_NEXT;
`ifdef COEFF_CHECKSUM_EN
                    if (r_w == c_CK_W) begin
                        if (r_xor != coeff_wbm_dat_i) begin
                            w_abort     = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_wr_en = 1'b1;
                    end
`else
                    w_wr_en = 1'b1;
`endif
                end else if (r_tmo == c_TMO_LAST) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_NEXT: begin
                w_state_nxt = (r_w == c_LAST_W) ? ST_WAIT_SWAP : ST_FETCH;
            end
            ST_WAIT_SWAP: begin
                if (sample_stb_i) begin
                    w_swap      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_base <= '0;
            r_w    <= '0;
            r_tmo  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_swap;
            if (w_start) begin
                r_base <= base_adr_i;
                r_w    <= '0;
                r_tmo  <= '0;
                r_err  <= 1'b0;
                r_busy <= 1'b1;
            end
            // Timeout restarts for every word
            if (r_state == ST_FETCH) begin
                r_tmo <= coeff_wbm_ack_i ? '0 : r_tmo + TMO_W'(1);
            end
            if (r_state == ST_NEXT) begin
                r_w <= r_w + W_W'(1);
            end
            if (w_abort) begin
                r_err  <= 1'b1;
                r_busy <= 1'b0;
            end
            if (w_swap) begin
                r_busy <= 1'b0;
            end
        end
    end

    biquad_coeff_bank #(
        .DATA_W (DATA_W),
        .N_SECT (N_SECT),
        .N_COEF (N_COEF),
        .WR_W   (W_W)
    ) u_bank (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_w),
        .i_wr_dat  (coeff_wbm_dat_i),
        .i_swap    (w_swap),
        .i_rd_sect (rd_sect_i),
        .i_rd_idx  (rd_idx_i),
        .o_rd_dat  (rd_dat_o)
    );

    // Address wraps naturally at the top of the space
    assign coeff_wbm_adr_o = r_base + ADDR_W'(r_w);
    assign coeff_wbm_cyc_o = w_cyc;
    assign coeff_wbm_stb_o = w_cyc;
    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign err_o           = r_err;

endmodule

`default_nettype wire

// File: tb/tb_wb_biquad_coeff_loader.sv
// ============================================================================
// Module      : tb_wb_biquad_coeff_loader
// Description : Directed, table-driven bench for wb_biquad_coeff_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wb_biquad_coeff_loader;

`ifdef COEFF_CHECKSUM_EN
    localparam int N_WORDS = 21;
`else
    localparam int N_WORDS = 20;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic [8:0]  adr;
    logic [63:0] dat;
    logic [8:0]  base_adr = '0;
    logic        load = 1'b0;
    logic        sample_stb = 1'b0;
    logic [1:0]  rd_sect = '0;
    logic [2:0]  rd_idx = '0;
    logic [63:0] rd_dat;
    logic        busy;
    logic        done;
    logic        err;
    logic        ack_en = 1'b1;
    logic        ack_force = 1'b0;
    logic [63:0] ram [512];

    assign ack = ack_en ? (cyc & stb) : ack_force;
    assign dat = ram[adr];

    always #5 clk = ~clk;

    wb_biquad_coeff_loader dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .coeff_wbm_cyc_o (cyc),
        .coeff_wbm_stb_o (stb),
        .coeff_wbm_adr_o (adr),
        .coeff_wbm_dat_i (dat),
        .coeff_wbm_ack_i (ack),
        .base_adr_i      (base_adr),
        .load_i          (load),
        .sample_stb_i    (sample_stb),
        .rd_sect_i       (rd_sect),
        .rd_idx_i        (rd_idx),
        .rd_dat_o        (rd_dat),
        .busy_o          (busy),
        .done_o          (done),
        .err_o           (err)
    );

    int         cyc_cnt = 0;
    int         done_cnt = 0;
    logic [8:0] adr_q [$];
    int         ack_cyc_q [$];

    always @(posedge clk) begin
        cyc_cnt++;
        if (!rst && cyc && stb && ack) begin
            adr_q.push_back(adr);
            ack_cyc_q.push_back(cyc_cnt);
        end
        if (!rst && done) done_cnt++;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [8:0] b);
        @(negedge clk);
        base_adr = b;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic pulse_sample();
        @(negedge clk);
        sample_stb = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [1:0] s, input logic [2:0] i,
                            input logic [63:0] exp);
        @(negedge clk);
        rd_sect = s;
        rd_idx  = i;
        @(negedge clk);
        check(name, rd_dat, exp);
    endtask

    task automatic wait_reads(input string name, input int n);
        int k = 0;
        while (adr_q.size() < n && k < 500) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(adr_q.size()), 64'(n));
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(busy), 64'd0);
    endtask

    typedef struct {
        logic [1:0]  sect;
        logic [2:0]  idx;
        logic [63:0] exp1;
        logic [63:0] exp2;
    } rd_vec_t;

    rd_vec_t vecs [8];

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int nbad;
        int n;
        int dc;
        logic [8:0] e_adr;

        for (int a = 0; a < 512; a++) ram[a] = 64'(a);
        // exp1: base 0x000 (value = flat index); exp2: base 0x1F8, wrapped
        vecs[0] = '{sect: 2'd0, idx: 3'd0, exp1: 64'h000, exp2: 64'h1F8};
        vecs[1] = '{sect: 2'd0, idx: 3'd4, exp1: 64'h004, exp2: 64'h1FC};
        vecs[2] = '{sect: 2'd1, idx: 3'd2, exp1: 64'h007, exp2: 64'h1FF};
        vecs[3] = '{sect: 2'd1, idx: 3'd3, exp1: 64'h008, exp2: 64'h000};
        vecs[4] = '{sect: 2'd2, idx: 3'd3, exp1: 64'h00D, exp2: 64'h005};
        vecs[5] = '{sect: 2'd3, idx: 3'd4, exp1: 64'h013, exp2: 64'h00B};
        vecs[6] = '{sect: 2'd0, idx: 3'd5, exp1: 64'h000, exp2: 64'h000};
        vecs[7] = '{sect: 2'd3, idx: 3'd7, exp1: 64'h000, exp2: 64'h000};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cyc", 64'(cyc), 64'd0);
        check("rst_stb", 64'(stb), 64'd0);
        check("rst_adr", 64'(adr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_rd_dat", rd_dat, 64'd0);
        rst = 1'b0;
`ifdef COEFF_CHECKSUM_EN
        ram[20] = 64'h0;
`endif

        // First load from base 0, with a stray sample strobe mid-fetch
        rd_sect = 2'd3;
        rd_idx  = 3'd4;
        do_load(9'h000);
        check("load_busy", 64'(busy), 64'd1);
        check("load_cyc", 64'(cyc), 64'd1);
        repeat (8) @(negedge clk);
        pulse_sample();
        check("midfetch_done", 64'(done), 64'd0);
        check("midfetch_busy", 64'(busy), 64'd1);
        check("midfetch_active", rd_dat, 64'd0);
        wait_reads("set1_reads", N_WORDS);
        repeat (3) @(negedge clk);
        check("wait_swap_busy", 64'(busy), 64'd1);
        check("wait_swap_no_done", 64'(done_cnt), 64'd0);
        check("wait_swap_active", rd_dat, 64'd0);
        nbad = 0;
        for (int i = 0; i < N_WORDS; i++) if (adr_q[i] !== 9'(i)) nbad++;
        check("set1_adr_seq", 64'(nbad), 64'd0);
        check("set1_word_spacing", 64'(ack_cyc_q[N_WORDS-1] - ack_cyc_q[0]), 64'(2*(N_WORDS-1)));

        do_load(9'h100);
        repeat (3) @(negedge clk);
        check("busy_load_ignored", 64'(adr_q.size()), 64'(N_WORDS));
        check("busy_load_no_cyc", 64'(cyc), 64'd0);

        pulse_sample();
        check("swap_done", 64'(done), 64'd1);
        check("swap_busy", 64'(busy), 64'd0);
        check("swap_rd_3_4", rd_dat, 64'h13);
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("done_count", 64'(done_cnt), 64'd1);
        for (int v = 0; v < 8; v++) read_chk("set1_rd", vecs[v].sect, vecs[v].idx, vecs[v].exp1);

        // Second load wrapping past the top of the address space
        adr_q.delete();
        ack_cyc_q.delete();
`ifdef COEFF_CHECKSUM_EN
        ram[12] = 64'h0;
`endif
        do_load(9'h1F8);
        wait_reads("set2_reads", N_WORDS);
        nbad = 0;
        for (int i = 0; i < N_WORDS; i++) begin
            e_adr = 9'h1F8 + 9'(i);
            if (adr_q[i] !== e_adr) nbad++;
        end
        check("set2_adr_wrap", 64'(nbad), 64'd0);
        check("set2_adr8", 64'(adr_q[8]), 64'h000);
        repeat (2) @(negedge clk);
        pulse_sample();
        check("set2_done", 64'(done), 64'd1);
        for (int v = 0; v < 8; v++) read_chk("set2_rd", vecs[v].sect, vecs[v].idx, vecs[v].exp2);

`ifdef COEFF_CHECKSUM_EN
        // Bad checksum word: coefficients XOR to 0xC, stored word is 0x55
        adr_q.delete();
        ram[20] = 64'h55;
        dc = done_cnt;
        do_load(9'h000);
        wait_idle("ck_bad_idle");
        check("ck_bad_reads", 64'(adr_q.size()), 64'd21);
        check("ck_bad_err", 64'(err), 64'd1);
        check("ck_bad_no_done", 64'(done_cnt), 64'(dc));
        read_chk("ck_bad_active_kept", 2'd3, 3'd4, 64'h00B);
`endif

        // Ack timeout
        ack_en = 1'b0;
        dc = done_cnt;
        do_load(9'h040);
        check("tmo_load_err_clear", 64'(err), 64'd0);
        check("tmo_load_busy", 64'(busy), 64'd1);
        n = 0;
        while (cyc && n < 400) begin
            n++;
            @(negedge clk);
        end
        check("tmo_cycles", 64'(n), 64'd255);
        check("tmo_err", 64'(err), 64'd1);
        check("tmo_busy", 64'(busy), 64'd0);
        check("tmo_stb", 64'(stb), 64'd0);
        ack_force = 1'b1;
        repeat (3) @(negedge clk);
        check("late_ack_cyc", 64'(cyc), 64'd0);
        check("late_ack_busy", 64'(busy), 64'd0);
        check("late_ack_err", 64'(err), 64'd1);
        check("late_ack_no_done", 64'(done_cnt), 64'(dc));
        ack_force = 1'b0;
        read_chk("tmo_active_3_4", 2'd3, 3'd4, 64'h00B);
        read_chk("tmo_active_1_2", 2'd1, 3'd2, 64'h1FF);

        ack_en = 1'b1;
        do_load(9'h000);
        check("reload_err_clear", 64'(err), 64'd0);
        check("reload_busy", 64'(busy), 64'd1);

        // Asynchronous reset in the middle of a fetch
        n = 0;
        while (!cyc && n < 10) begin
            n++;
            @(negedge clk);
        end
        check("pre_rst_cyc", 64'(cyc), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_cyc", 64'(cyc), 64'd0);
        check("async_rst_stb", 64'(stb), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        read_chk("post_rst_3_4", 2'd3, 3'd4, 64'd0);
        read_chk("post_rst_1_2", 2'd1, 3'd2, 64'd0);
        check("post_rst_err", 64'(err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
